// File: rtl/shift_display_pkg.sv
// Shared definitions for the multi-digit 74HC595-style display driver:
// FSM state encoding, segment bit positions and the hex glyph table.
package shift_display_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit positions inside one segment byte (active-high segments).
  localparam int SEG_A      = 0;
  localparam int SEG_B      = 1;
  localparam int SEG_C      = 2;
  localparam int SEG_D      = 3;
  localparam int SEG_E      = 4;
  localparam int SEG_F      = 5;
  localparam int SEG_G      = 6;
  localparam int SEG_DP     = 7;
  localparam int SEG_BYTE_W = 8;

  // Standard hex glyphs, bits g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
    logic [6:0] v_seg;
    case (i_nib)
      4'h0: v_seg = 7'h3F;
      4'h1: v_seg = 7'h06;
      4'h2: v_seg = 7'h5B;
      4'h3: v_seg = 7'h4F;
      4'h4: v_seg = 7'h66;
      4'h5: v_seg = 7'h6D;
      4'h6: v_seg = 7'h7D;
      4'h7: v_seg = 7'h07;
      4'h8: v_seg = 7'h7F;
      4'h9: v_seg = 7'h6F;
      4'hA: v_seg = 7'h77;
      4'hB: v_seg = 7'h7C;
      4'hC: v_seg = 7'h39;
      4'hD: v_seg = 7'h5E;
      4'hE: v_seg = 7'h79;
      default: v_seg = 7'h71;
    endcase
    return v_seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph (bits g..a, active-high).
module seg7_hex_decoder
  import shift_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/multi_digit_shift_display.sv
// Drives a chain of DIGITS 8-bit serial-in shift registers with one segment
// byte per digit. Frame order: digit DIGITS-1 first, bit7 (dp) first.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero digit (digit 0 is never blanked, dp is kept).
//
// Handshake: a transfer happens on an i_clk rising edge where i_valid and
// o_ready are both high; o_ready is high only in IDLE, and i_valid is
// ignored (data held) for the whole frame until o_done has pulsed.
module multi_digit_shift_display
  import shift_display_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 4,
  parameter int CLK_DIV_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp,
  output logic                  o_sr_ds,
  output logic                  o_sr_cp,
  output logic                  o_sr_mr_n,
  output logic                  o_done,
  output logic [1:0]            o_dbg_state
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BIT_W = $clog2(SEG_BYTE_W);
  localparam logic [CLK_DIV_WIDTH-1:0] DIV_LAST  = CLK_DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [CLK_DIV_WIDTH:0]   CLR_LAST  = (CLK_DIV_WIDTH + 1)'(2 * CLK_DIV - 1);
  localparam logic [DIG_W-1:0]         DIG_FIRST = DIG_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0]         BIT_FIRST = BIT_W'(SEG_BYTE_W - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CLK_DIV_WIDTH:0]   r_clr_cnt;
  logic [CLK_DIV_WIDTH-1:0] r_div_cnt;
  logic [DIG_W-1:0]         r_dig_idx;
  logic [BIT_W-1:0]         r_bit_idx;
  logic                     r_fin;
  logic                     r_cp;
  logic                     r_ds;
  logic [7:0]               r_seg [DIGITS];
  logic [6:0]               w_glyph [DIGITS];
  logic [7:0]               w_seg [DIGITS];
  logic                     w_transfer;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_hex_decoder u_dec (
      .i_nibble (i_digits[4*g +: 4]),
      .o_seg    (w_glyph[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Build segment bytes, blanking zero digits above the highest nonzero one.
  always_comb begin
    logic v_upper_zero;
    v_upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_upper_zero = v_upper_zero && (i_digits[4*k +: 4] == 4'h0);
      w_seg[k] = {i_dp[k], (v_upper_zero && (k != 0)) ? 7'h00 : w_glyph[k]};
    end
  end
`else
  // Build segment bytes: dp on top of the plain glyph.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_seg[k] = {i_dp[k], w_glyph[k]};
    end
  end
`endif

  assign w_transfer  = (r_state == ST_IDLE) && i_valid;
  assign o_ready     = (r_state == ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_sr_mr_n   = (r_state != ST_CLEAR);
  assign o_sr_cp     = r_cp;
  assign o_sr_ds     = r_ds;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_CLEAR;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == CLR_LAST) w_next_state = ST_IDLE;
      ST_IDLE:  if (i_valid)               w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_fin)                 w_next_state = ST_DONE;
      ST_DONE:                             w_next_state = ST_IDLE;
      default:                             w_next_state = ST_CLEAR;
    endcase
  end

  // Clear timer, shift-clock divider, bit/digit counters and serial data.
  // Data only changes on the cycle o_sr_cp falls, so it is stable for the
  // whole low phase ahead of each rising edge. After the last bit the
  // counters stop at zero and r_fin is raised instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clr_cnt <= '0;
      r_div_cnt <= '0;
      r_dig_idx <= '0;
      r_bit_idx <= '0;
      r_fin     <= 1'b0;
      r_cp      <= 1'b0;
      r_ds      <= 1'b0;
      for (int k = 0; k < DIGITS; k++) r_seg[k] <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cp <= 1'b0;
          r_ds <= 1'b0;
          if (r_clr_cnt == CLR_LAST) r_clr_cnt <= '0;
          else                       r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        ST_IDLE: begin
          r_cp <= 1'b0;
          r_ds <= 1'b0;
          if (w_transfer) begin
            for (int k = 0; k < DIGITS; k++) r_seg[k] <= w_seg[k];
            r_div_cnt <= '0;
            r_dig_idx <= DIG_FIRST;
            r_bit_idx <= BIT_FIRST;
            r_fin     <= 1'b0;
            r_ds      <= w_seg[DIGITS-1][SEG_DP];
          end
        end
        ST_SHIFT: begin
          if (r_div_cnt != DIV_LAST) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt <= '0;
            if (!r_cp) begin
              if (!r_fin) r_cp <= 1'b1;
            end else begin
              r_cp <= 1'b0;
              if ((r_bit_idx == '0) && (r_dig_idx == '0)) begin
                r_fin <= 1'b1;
                r_ds  <= 1'b0;
              end else if (r_bit_idx == '0) begin
                r_dig_idx <= r_dig_idx - 1'b1;
                r_bit_idx <= BIT_FIRST;
                r_ds      <= r_seg[r_dig_idx - 1'b1][SEG_DP];
              end else begin
                r_bit_idx <= r_bit_idx - 1'b1;
                r_ds      <= r_seg[r_dig_idx][r_bit_idx - 1'b1];
              end
            end
          end
        end
        default: begin
          r_cp <= 1'b0;
          r_ds <= 1'b0;
          r_fin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_digit_shift_display.sv
// Bench for multi_digit_shift_display (DIGITS=4, CLK_DIV=2). Honours the
// LEADING_ZERO_BLANK_EN macro when choosing expected segment bytes.
module tb_multi_digit_shift_display;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 2;
  localparam int LAT     = 16 * DIGITS * CLK_DIV + 1;
  localparam int NBITS   = 8 * DIGITS;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_digits = '0;
  logic [3:0]  i_dp = '0;
  logic        o_sr_ds, o_sr_cp, o_sr_mr_n, o_done;
  logic [1:0]  o_dbg_state;

  multi_digit_shift_display #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .CLK_DIV_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_digits(i_digits), .i_dp(i_dp), .o_sr_ds(o_sr_ds), .o_sr_cp(o_sr_cp),
    .o_sr_mr_n(o_sr_mr_n), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected 32-bit stream, first transmitted bit in the MSB.
  function automatic logic [31:0] model_frame(input logic [15:0] d, input logic [3:0] dp);
    logic [31:0] w;
    logic [15:0] sh;
    logic [7:0]  b;
    w = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      sh = d >> (4 * k);
      b  = {dp[k], glyph_tab[sh[3:0]]};
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && sh == 16'h0) b[6:0] = 7'h00;
`endif
      w = {w[23:0], b};
    end
    return w;
  endfunction

  // ---------------- monitor ----------------
  logic bitq[$];
  logic prev_cp = 1'b0;
  logic prev_ds = 1'b0;
  int   ds_glitch = 0;
  int   mr_low_cnt = 0;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (o_sr_cp && !prev_cp) begin
      bitq.push_back(o_sr_ds);
      if (o_sr_ds != prev_ds) ds_glitch <= ds_glitch + 1;
    end
    prev_cp <= o_sr_cp;
    prev_ds <= o_sr_ds;
    if (!o_sr_mr_n) mr_low_cnt <= mr_low_cnt + 1;
    if (o_done)     done_cnt   <= done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  int t0 = 0, base = 0, glitch0 = 0, mr0 = 0;
  bit scramble_en = 0;

  task automatic release_reset(input string tag);
    int  n;
    bit  low_ok;
    @(negedge clk);
    i_reset = 1'b0;
    n = 0;
    low_ok = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (o_ready) break;
      if (o_sr_mr_n) low_ok = 0;
    end
    check({tag, "_clear_len"}, n, 4);
    check({tag, "_clear_mr_low"}, {31'b0, low_ok}, 1);
    check({tag, "_idle_mr_n"}, {31'b0, o_sr_mr_n}, 1);
    check({tag, "_idle_cp_ds"}, {30'b0, o_sr_cp, o_sr_ds}, 0);
  endtask

  task automatic start_frame(input logic [15:0] d, input logic [3:0] dp, output bit ok);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      if (o_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_digits = d;
    i_dp     = dp;
    i_valid  = 1'b1;
    exp_q.push_back(model_frame(d, dp));
    @(posedge clk);
    #1;
    t0 = cyc;
    base = bitq.size();
    glitch0 = ds_glitch;
    mr0 = mr_low_cnt;
    check("accept_ready_low", {31'b0, o_ready}, 0);
  endtask

  task automatic finish_frame(input string tag);
    bit          ok;
    int          lat;
    int          nb;
    logic [31:0] word;
    logic [31:0] exp;
    ok = 0;
    lat = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (o_done) begin ok = 1; lat = cyc - t0; break; end
      if (scramble_en) i_digits = 16'($urandom);
    end
    scramble_en = 0;
    check({tag, "_done_seen"}, {31'b0, ok}, 1);
    check({tag, "_latency"}, lat, LAT);
    nb = bitq.size() - base;
    check({tag, "_nbits"}, nb, NBITS);
    word = '0;
    for (int i = 0; i < NBITS; i++)
      word = {word[30:0], (base + i < bitq.size()) ? bitq[base + i] : 1'b0};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_stream"}, word, exp);
    check({tag, "_ds_stable"}, ds_glitch - glitch0, 0);
    check({tag, "_mr_n_high"}, mr_low_cnt - mr0, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {30'b0, o_done, o_ready}, 2'b01);
  endtask

  task automatic run_frame(input logic [15:0] d, input logic [3:0] dp, input string tag);
    bit ok;
    start_frame(d, dp, ok);
    if (!ok) return;
    i_valid = 1'b0;
    finish_frame(tag);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [31:0] exp_plain;
    logic [31:0] exp_blank;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int d0;
    logic [15:0] v1, v2;
    logic [3:0]  pdp;
    logic [31:0] e;

    vecs[0] = '{16'h1234, 4'b0000, 32'h065B4F66, 32'h065B4F66};
    vecs[1] = '{16'h00F0, 4'b0100, 32'h3FBF713F, 32'h0080713F};
    vecs[2] = '{16'h0000, 4'b0000, 32'h3F3F3F3F, 32'h0000003F};
    vecs[3] = '{16'hFFFF, 4'b1111, 32'hF1F1F1F1, 32'hF1F1F1F1};
    vecs[4] = '{16'h0008, 4'b1000, 32'hBF3F3F7F, 32'h8000007F};
    vecs[5] = '{16'h00A0, 4'b0000, 32'h3F3F773F, 32'h0000773F};

    // Reset state while held.
    #1;
    check("rst_mr_n", {31'b0, o_sr_mr_n}, 0);
    check("rst_ready", {31'b0, o_ready}, 0);
    check("rst_cp_ds", {30'b0, o_sr_cp, o_sr_ds}, 0);
    check("rst_done", {31'b0, o_done}, 0);
    check("rst_state", {30'b0, o_dbg_state}, 0);
    #20;
    release_reset("init");

    // Directed table.
    for (int i = 0; i < 6; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      e = vecs[i].exp_blank;
`else
      e = vecs[i].exp_plain;
`endif
      check("table_model", model_frame(vecs[i].d, vecs[i].dp), e);
      run_frame(vecs[i].d, vecs[i].dp, "table");
    end

    // Random frames, some with leading zeros.
    for (int i = 0; i < 8; i++) begin
      v1  = 16'($urandom_range(0, 65535));
      v1  = v1 >> (4 * $urandom_range(0, 3));
      pdp = 4'($urandom_range(0, 15));
      run_frame(v1, pdp, "rand");
    end

    // i_valid held high with changing digits: one frame, first value only;
    // the next transfer lands on the edge right after o_done.
    v1 = 16'h5A3C; v2 = 16'h0E07; pdp = 4'b0010;
    start_frame(v1, pdp, ok);
    if (ok) begin
      scramble_en = 1;
      finish_frame("hold");
      i_digits = v2;
      @(negedge clk);
      check("hold_next_transfer", {31'b0, o_ready}, 0);
      t0 = cyc;
      base = bitq.size();
      glitch0 = ds_glitch;
      mr0 = mr_low_cnt;
      exp_q.push_back(model_frame(v2, pdp));
      i_valid = 1'b0;
      finish_frame("hold2");
    end

    // Reset around bit 10 of a frame.
    start_frame(16'h9876, 4'b0001, ok);
    if (ok) begin
      i_valid = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (bitq.size() - base >= 10) break;
      end
      d0 = done_cnt;
      #2 i_reset = 1'b1;
      #1;
      check("midrst_outputs", {27'b0, o_sr_mr_n, o_sr_cp, o_sr_ds, o_ready, o_done}, 0);
      check("midrst_state", {30'b0, o_dbg_state}, 0);
      void'(exp_q.pop_front());
      repeat (2) @(negedge clk);
      release_reset("midrst");
      check("midrst_no_done", done_cnt - d0, 0);
    end
    run_frame(16'h1234, 4'b1001, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/multi_digit_shift_display.md
MULTI_DIGIT_SHIFT_DISPLAY -- requirements
Module: multi_digit_shift_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of 7-segment digits, one 8-bit serial-in shift register per digit, chained.
REQ-002 SHALL have parameter CLK_DIV, default 4: shift-clock half-period in i_clk cycles, minimum 1.
REQ-003 SHALL have parameter CLK_DIV_WIDTH, default 8: divider counter width, sized to hold CLK_DIV.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic sits in this domain.
REQ-005 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1 bit: a new display value is offered.
REQ-007 SHALL have port o_ready, output, 1 bit: the block can accept a value.
REQ-008 SHALL have port i_digits, input, 4*DIGITS bits: hex nibble per digit; nibble k is digit k, and digit 0 is least significant.
REQ-009 SHALL have port i_dp, input, DIGITS bits: decimal point per digit.
REQ-010 SHALL have port o_sr_ds, output, 1 bit: serial data to the first register.
REQ-011 SHALL have port o_sr_cp, output, 1 bit: shift clock; registers sample on its rising edge.
REQ-012 SHALL have port o_sr_mr_n, output, 1 bit: active-low master reset to all registers.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-014 SHALL implement FSM states CLEAR, IDLE, SHIFT, DONE.
REQ-015 CLEAR SHALL drive o_sr_mr_n=0 and o_ready=0 for 2*CLK_DIV cycles, then go to IDLE.
REQ-016 IDLE SHALL drive o_ready=1; a transfer (i_valid&&o_ready at an i_clk edge) SHALL capture i_digits/i_dp and go to SHIFT; o_ready=0 in every other state.
REQ-017 Each digit SHALL be encoded as an 8-bit segment byte: bit7=dp, bit6..0=g,f,e,d,c,b,a, active-high, standard hex glyphs 0-F (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, F=0x71).
REQ-018 SHALL output the bit stream digit DIGITS-1 first, then down to digit 0, MSB (bit7) first within each byte; total 8*DIGITS bits.
REQ-019 Each bit SHALL span 2*CLK_DIV cycles: o_sr_cp low for the first CLK_DIV cycles and high for the next CLK_DIV; o_sr_ds SHALL change only while o_sr_cp is low and be stable CLK_DIV cycles before each rising edge.
REQ-020 SHIFT SHALL move to DONE after the falling edge of o_sr_cp following the last bit; DONE SHALL assert o_done for one cycle, then go to IDLE.
REQ-021 Latency from the transfer edge to o_done high SHALL be exactly 16*DIGITS*CLK_DIV+1 cycles.
REQ-022 In SHIFT, o_sr_mr_n SHALL stay 1; i_valid SHALL be ignored; captured data SHALL not change.
REQ-023 In IDLE, o_sr_cp=0, o_sr_ds=0 and o_sr_mr_n=1.
REQ-024 Bit and digit counters SHALL use $clog2 widths, with no wrap-around before the final bit.

Reset
REQ-025 Asserting i_reset SHALL immediately force: state CLEAR, o_sr_mr_n=0, o_sr_cp=0, o_sr_ds=0, o_ready=0, o_done=0, all counters 0.
REQ-026 Reset mid-SHIFT SHALL abandon the frame with no o_done; after release, CLEAR SHALL run in full before IDLE.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, zero digits above the most significant nonzero digit SHALL have segment bits 6..0 forced to 0; dp SHALL be unaffected, and digit 0 SHALL never be blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its glyph, and no blanking logic SHALL be present.

Structure
REQ-029 Package shift_display_pkg SHALL hold the FSM state enum, segment bit-position constants and the hex-to-segment table.
REQ-030 Hex-to-segment decoding SHALL be a combinational sub-module seg7_hex_decoder, instantiated once per digit.

Verification (DIGITS=4, CLK_DIV=2)
REQ-031 Release reset -> o_sr_mr_n low for 4 cycles, then o_ready=1 and o_sr_mr_n=1.
REQ-032 i_digits=16'h1234, i_dp=0 -> captured stream on o_sr_cp rising edges = 0x06,0x5B,0x4F,0x66 MSB-first; o_done at cycle 129 after transfer.
REQ-033 i_digits=16'h00F0, i_dp=4'b0100 -> bytes 0x3F,0xBF,0x71,0x3F without the macro; 0x00,0x80,0x71,0x3F with LEADING_ZERO_BLANK_EN.
REQ-034 i_valid held high through a frame with changing i_digits -> only one frame, with the first value; next transfer occurs the cycle after o_done.
REQ-035 i_reset pulsed at bit 10 of a frame -> outputs zero asynchronously, no o_done, CLEAR then IDLE; next frame is correct.
REQ-036 i_digits=16'h0000 with the macro -> 0x00,0x00,0x00,0x3F.
